router_param: RTL and testbench
===============================

# router_param

Parametrised N-channel packet router. A byte stream enters one input port, and each packet is steered by its header to one of `N_CH` per-channel FIFOs. Compared with the fixed 3-channel router it adds space-based admission with back-pressure and whole-packet buffering (header, payload and parity). It also drops packets with an illegal destination or oversize length, and flushes any channel whose reader stalls too long. It sits between the serial packet source and the per-channel output readers in the top-level wrapper.

## Interface
- `DATA_W`, 8: byte width.
- `N_CH`, 3: number of output channels (1..2^ADDR_W).
- `ADDR_W`, 2: header destination field width, `hdr[ADDR_W-1:0]`. Length field `L = hdr[DATA_W-1:ADDR_W]`.
- `DEPTH`, 16: per-channel FIFO depth in words. Must be a power of 2 and at least 4.
- `TIMEOUT`, 30: cycles of unread valid data before a channel is flushed.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: one clock; reset is synchronous and active-high.
- `packet_valid`, in, 1: source has a byte on `datain`.
- `datain`, in, DATA_W: packet byte.
- `read_enb`, in, N_CH: per-channel pop request.
- `busy`, out, 1: input not accepting; source must hold `datain`.
- `vldout`, out, N_CH: channel FIFO non-empty.
- `data_out`, out, N_CH*DATA_W: head word of channel i on `[i*DATA_W +: DATA_W]`; 0 when empty.
- `err`, out, 1: one-cycle pulse on parity mismatch or truncated packet.
- `drop`, out, 1: one-cycle pulse when a packet is discarded.
- `timeout`, out, N_CH: one-cycle pulse when channel i is flushed.

## Operation
- Byte transfer: a byte is accepted on a rising edge where `packet_valid=1` and `busy=0`.
- Packet format: header, then L payload bytes, then 1 parity byte, giving L+2 bytes total. L=0 is legal. Parity = XOR of header and all payload bytes.
- FSM state IDLE:
  - `busy=0`.
  - An accepted byte is latched as the header. `calc_parity` is set to the header. Next state is WAIT.
- FSM state WAIT:
  - `busy=1`.
  - If dest ≥ N_CH or L+2 > DEPTH: pulse `drop` and go to DROP.
  - Otherwise, if `DEPTH - count[dest] ≥ L+2`: write the latched header into FIFO[dest], load `remaining = L+1`, and go to LOAD.
  - Otherwise stay in WAIT (back-pressure).
  - Free space uses the registered count; a same-cycle pop does not count toward it.
- FSM state LOAD:
  - `busy=0`. Each accepted byte is written to FIFO[dest] and `remaining` decrements.
  - Payload bytes are XORed into `calc_parity`.
  - The byte accepted when `remaining==1` is the parity byte. It is written, and `err` pulses the next cycle if it differs from `calc_parity`. Next state is IDLE.
  - If `packet_valid=0` while `remaining>0`: the packet is truncated. Pulse `err`, go to IDLE, and leave the bytes already written in the FIFO.
- FSM state DROP:
  - `busy=0`. L+1 further accepted bytes are consumed without being written, then go to IDLE.
  - `packet_valid=0` also returns to IDLE, with no `err`.
- FIFO behaviour:
  - Show-ahead: `data_out[i]` is the head word and `vldout[i] = (count[i] != 0)`.
  - Pop when `read_enb[i] && vldout[i]`. `read_enb` on an empty FIFO is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
  - Admission guarantees a push never targets a full FIFO.
- Timeout:
  - `tcnt[i]` increments each cycle that `vldout[i]=1` and `read_enb[i]=0`.
  - It clears on any pop cycle or when the FIFO is empty.
  - It is held at 0 while channel i is the active destination (WAIT or LOAD with dest=i).
  - When `tcnt[i]` reaches TIMEOUT-1: next edge sets `count[i]` and both pointers to 0, and `timeout[i]` pulses.

## Timing
- Reset (`rst=1` at a rising edge):
  - FSM goes to IDLE; all counts, pointers and `tcnt` are cleared.
  - `busy`, `err`, `drop`, `timeout` and `vldout` are 0; `data_out` is all 0.
  - A reset mid-packet discards all state, and the next byte is treated as a header.
- Header latency: header accepted at edge T. WAIT is active T..T+1, so `busy=1` for at least one cycle. With space available the header is written at edge T+1, `vldout[dest]=1` after T+1, and payload is accepted from edge T+2.
- Write-to-visible latency is 1 cycle. Pop takes effect at the edge; the next head word appears after that edge.
- `err` is asserted in the cycle after the parity byte's accept edge, or the cycle after the truncation edge. `drop` is asserted in the cycle after the WAIT decision edge.
- Timeout flush happens exactly TIMEOUT cycles after the first unread-valid cycle.

## Test plan
- **Good packet:** reset, then send header `0x09` (dest 1, L=2), payload `0xAA`, `0x55`, parity `0xF6`. Required: FIFO1 holds `09 AA 55 F6`, `err=0`, `vldout=3'b010`. Pop 4× reads back that order, after which `vldout=0`.
- **Bad parity:** same packet with parity `0x00`. Required: `err` pulses 1 cycle and the packet is still stored (4 words).
- **Illegal destination:** header `0x07` (dest 3, N_CH=3, L=1), then 2 more bytes. Required: `drop` pulse, no `vldout` change, and the FSM accepts the next header.
- **Back-pressure:** FIFO0 is filled to 14/16, then a packet with L=2 (4 bytes) is sent to ch0. Required: `busy` stays 1 until 2 pops free space; then the header is written and the packet completes.
- **Timeout and concurrency:** leave ch2 with 1 word unread for 30 cycles. Required: `timeout[2]` pulses and `vldout[2]` falls. Separately, a push and pop in the same cycle on ch0 keeps the count steady and the order intact across pointer wrap (>16 words).
- **Truncation and reset:** drop `packet_valid` after 1 of 3 payload bytes. Required: `err` pulse, return to IDLE. Asserting `rst` mid-LOAD clears all outputs to 0 on the next edge.

Source files
------------

// File: rtl/router_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : router_param_if                                            |
// | Description : Byte-stream and per-channel read bundle of the packet      |
// |               router.                                                    |
// |               master : packet source and channel readers                 |
// |                        drives packet_valid, datain, read_enb             |
// |               slave  : router; drives busy, vldout, data_out, err, drop, |
// |                        timeout                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface router_param_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 3
);
    logic                   packet_valid;
    logic [DATA_W-1:0]      datain;
    logic [N_CH-1:0]        read_enb;
    logic                   busy;
    logic [N_CH-1:0]        vldout;
    logic [N_CH*DATA_W-1:0] data_out;
    logic                   err;
    logic                   drop;
    logic [N_CH-1:0]        timeout;

    modport master (
        output packet_valid, datain, read_enb,
        input  busy, vldout, data_out, err, drop, timeout
    );

    modport slave (
        input  packet_valid, datain, read_enb,
        output busy, vldout, data_out, err, drop, timeout
    );
endinterface
`default_nettype wire

// File: rtl/router_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : router_param                                               |
// | Description : N-channel packet router. Each packet (header, L payload    |
// |               bytes, parity) is admitted only when its destination FIFO  |
// |               can hold all L+2 words; illegal or oversize packets are    |
// |               consumed and dropped; a channel left unread for TIMEOUT    |
// |               cycles is flushed.                                         |
// | Ports       : clk  - clock, rising edge                                  |
// |               rst  - synchronous active-high reset                       |
// |               bus  - router_param_if.slave (byte input, channel outputs, |
// |                      err/drop/timeout pulses)                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module router_param #(
    parameter int DATA_W  = 8,
    parameter int N_CH    = 3,
    parameter int ADDR_W  = 2,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic          clk,
    input  logic          rst,
    router_param_if.slave bus
);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_len_w  = DATA_W - ADDR_W;
    localparam int c_rem_w  = c_len_w + 1;
    localparam int c_tcnt_w = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_load = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_hdr;
    logic [DATA_W-1:0]  r_parity;
    logic [c_rem_w-1:0] r_remaining;
    logic               r_err;
    logic               r_drop;

    logic [ADDR_W-1:0]               w_dest;
    logic [c_len_w-1:0]              w_len;
    logic [c_rem_w-1:0]              w_rem_init;
    logic [31:0]                     w_need;
    logic                            w_legal;
    logic                            w_space;
    logic [c_cnt_w-1:0]              w_sel_count;
    logic                            w_in_wait;
    logic                            w_in_load;
    logic                            w_push;
    logic [DATA_W-1:0]               w_push_data;
    logic [N_CH-1:0][c_cnt_w-1:0]    w_count;
    logic [N_CH-1:0]                 w_vld;
    logic [N_CH-1:0]                 w_tmo;
    logic [N_CH-1:0][DATA_W-1:0]     w_head;

    assign w_dest     = r_hdr[ADDR_W-1:0];
    assign w_len      = r_hdr[DATA_W-1:ADDR_W];
    assign w_rem_init = {1'b0, w_len} + c_rem_w'(1);
    assign w_need     = 32'(w_len) + 32'd2;
    assign w_legal    = (32'(w_dest) < 32'(N_CH)) && (w_need <= 32'(DEPTH));
    // Free space is judged on the registered count only, so a pop in the
    // same cycle does not help admission until the following cycle.
    assign w_space    = (32'(DEPTH) - 32'(w_sel_count)) >= w_need;
    assign w_in_wait  = (r_state == c_st_wait);
    assign w_in_load  = (r_state == c_st_load);

    // The header is written on the admission edge; payload and parity are
    // written as they are accepted in LOAD (busy is low there).
    assign w_push      = (w_in_wait && w_legal && w_space) || (w_in_load && bus.packet_valid);
    assign w_push_data = w_in_wait ? r_hdr : bus.datain;

    always_comb begin
        w_sel_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (32'(w_dest) == 32'(i)) begin
                w_sel_count = w_count[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_hdr       <= '0;
            r_parity    <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.packet_valid) begin
                        r_hdr    <= bus.datain;
                        r_parity <= bus.datain;
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (!w_legal) begin
                        r_drop      <= 1'b1;
                        r_remaining <= w_rem_init;
                        r_state     <= c_st_drop;
                    end else if (w_space) begin
                        r_remaining <= w_rem_init;
                        r_state     <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (!bus.packet_valid) begin
                        // Truncated packet: words already stored stay in the FIFO.
                        r_err   <= 1'b1;
                        r_state <= c_st_idle;
                    end else if (r_remaining == c_rem_w'(1)) begin
                        r_err   <= (bus.datain != r_parity);
                        r_state <= c_st_idle;
                    end else begin
                        r_parity    <= r_parity ^ bus.datain;
                        r_remaining <= r_remaining - c_rem_w'(1);
                    end
                end
                c_st_drop: begin
                    if (!bus.packet_valid || (r_remaining == c_rem_w'(1))) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_remaining <= r_remaining - c_rem_w'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DATA_W-1:0]   r_mem [DEPTH];
        logic [c_ptr_w-1:0]  r_wr_ptr;
        logic [c_ptr_w-1:0]  r_rd_ptr;
        logic [c_cnt_w-1:0]  r_count;
        logic [c_tcnt_w-1:0] r_tcnt;
        logic                r_timeout;
        logic                w_wr;
        logic                w_rd;
        logic                w_active;
        logic                w_flush;

        assign w_wr     = w_push && (32'(w_dest) == g);
        assign w_rd     = bus.read_enb[g] && (r_count != '0);
        assign w_active = (w_in_wait || w_in_load) && (32'(w_dest) == g);
        // tcnt is forced to 0 while the channel is being filled, so a flush
        // can never collide with a push.
        assign w_flush  = !w_active && (r_tcnt == c_tcnt_w'(TIMEOUT - 1));

        always_ff @(posedge clk) begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_tcnt    <= '0;
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= w_flush;
                if (w_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                    if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                    case ({w_wr, w_rd})
                        2'b10:   r_count <= r_count + c_cnt_w'(1);
                        2'b01:   r_count <= r_count - c_cnt_w'(1);
                        default: r_count <= r_count;
                    endcase
                end
                if (w_flush || w_active || w_rd || (r_count == '0)) begin
                    r_tcnt <= '0;
                end else begin
                    r_tcnt <= r_tcnt + c_tcnt_w'(1);
                end
            end
        end

        assign w_count[g] = r_count;
        assign w_vld[g]   = (r_count != '0);
        assign w_head[g]  = w_vld[g] ? r_mem[r_rd_ptr] : '0;
        assign w_tmo[g]   = r_timeout;
    end

    assign bus.busy     = w_in_wait;
    assign bus.err      = r_err;
    assign bus.drop     = r_drop;
    assign bus.vldout   = w_vld;
    assign bus.data_out = w_head;
    assign bus.timeout  = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_router_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_router_param                                            |
// | Description : Self-checking bench for router_param. Packets are built    |
// |               from header/length/parity rules and a per-channel queue    |
// |               model predicts the words each reader must see.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_router_param;
    localparam int DATA_W  = 8;
    localparam int N_CH    = 3;
    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic clk = 1'b0;
    logic rst = 1'b0;

    router_param_if #(.DATA_W(DATA_W), .N_CH(N_CH)) intf ();

    router_param #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;
    int tmo_cnt [N_CH];
    int exp_err  = 0;
    int exp_drop = 0;
    logic [7:0] exp_q [N_CH][$];
    logic [7:0] tx_q [$];

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (intf.err === 1'b1) err_cnt++;
        if (intf.drop === 1'b1) drop_cnt++;
        for (int i = 0; i < N_CH; i++) begin
            if (intf.timeout[i] === 1'b1) tmo_cnt[i]++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, output int waits);
        int n;
        n = 0;
        intf.packet_valid = 1'b1;
        intf.datain       = b;
        while (1) begin
            @(negedge clk);
            if (intf.busy === 1'b0) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_bound: busy=%b after %0d cycles, required 0", intf.busy, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        waits = n;
    endtask

    // Reference: what the packet in tx_q should do to the channel queues.
    task automatic model_packet();
        logic [7:0] hdr;
        logic [7:0] par;
        int dest;
        int len;
        hdr  = tx_q[0];
        dest = int'(hdr[1:0]);
        len  = int'(hdr[7:2]);
        if (dest >= N_CH || len + 2 > DEPTH) begin
            exp_drop++;
        end else begin
            par = 8'h00;
            for (int i = 0; i <= len; i++) par = par ^ tx_q[i];
            if (tx_q[len+1] !== par) exp_err++;
            foreach (tx_q[i]) exp_q[dest].push_back(tx_q[i]);
        end
    endtask

    task automatic send_packet(output int hdr_wait);
        int w;
        model_packet();
        hdr_wait = 0;
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], w);
            if (i == 1) hdr_wait = w;
        end
        intf.packet_valid = 1'b0;
    endtask

    task automatic make_packet(input int dest, input int len, input bit good);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        tx_q.delete();
        hdr = {6'(len), 2'(dest)};
        tx_q.push_back(hdr);
        par = hdr;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            tx_q.push_back(b);
            par = par ^ b;
        end
        if (!good) par = par ^ 8'($urandom_range(1, 255));
        tx_q.push_back(par);
    endtask

    task automatic pop_one(input int ch, input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        exp = exp_q[ch].pop_front();
        intf.read_enb[ch] = 1'b1;
        @(negedge clk);
        got = intf.data_out[ch*DATA_W +: DATA_W];
        n_checks++;
        if (intf.vldout[ch] !== 1'b1 || got !== exp) begin
            n_fail++;
            $display("FAIL %s_pop ch%0d: vld=%b data=%h, required vld=1 data=%h",
                     tag, ch, intf.vldout[ch], got, exp);
        end
        @(posedge clk);
        #1;
        intf.read_enb[ch] = 1'b0;
    endtask

    task automatic drain(input int ch, input string tag);
        while (exp_q[ch].size() > 0) pop_one(ch, tag);
        n_checks++;
        if (intf.vldout[ch] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_empty ch%0d: vld=%b, required 0", tag, ch, intf.vldout[ch]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        intf.packet_valid = 1'b1;
        intf.datain = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        intf.packet_valid = 1'b0;
        n_checks++;
        if (intf.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", intf.busy); end
        n_checks++;
        if (intf.vldout !== 3'b000) begin n_fail++; $display("FAIL rst_vldout: got %b, required 000", intf.vldout); end
        n_checks++;
        if (intf.data_out !== 24'h0) begin n_fail++; $display("FAIL rst_data_out: got %h, required 0", intf.data_out); end
        n_checks++;
        if (intf.err !== 1'b0 || intf.drop !== 1'b0 || intf.timeout !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_pulses: err=%b drop=%b timeout=%b, required 0 0 000", intf.err, intf.drop, intf.timeout);
        end
    endtask

    task automatic test_good_packet();
        int hw;
        tx_q = {8'h09, 8'hAA, 8'h55, 8'hF6};
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (hw != 1) begin n_fail++; $display("FAIL hdr_latency: busy cycles %0d, required 1", hw); end
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL good_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        n_checks++;
        if (intf.vldout !== 3'b010) begin n_fail++; $display("FAIL good_vldout: got %b, required 010", intf.vldout); end
        drain(1, "good");
    endtask

    task automatic test_bad_parity();
        int hw;
        tx_q = {8'h09, 8'hAA, 8'h55, 8'h00};
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL badpar_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        drain(1, "badpar");
    endtask

    task automatic test_illegal_dest();
        int hw;
        tx_q = {8'h07, 8'h11, 8'h22};
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (drop_cnt != exp_drop) begin n_fail++; $display("FAIL drop_pulse: drop pulses %0d, required %0d", drop_cnt, exp_drop); end
        n_checks++;
        if (intf.vldout !== 3'b000 || intf.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_state: vldout=%b busy=%b, required 000 0", intf.vldout, intf.busy);
        end
        tx_q = {8'h04, 8'h33, 8'h37};
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL drop_next_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        drain(0, "drop_next");
    endtask

    task automatic test_back_pressure();
        int hw;
        int w;
        bit held;
        make_packet(0, 12, 1'b1);
        send_packet(hw);
        make_packet(0, 2, 1'b1);
        model_packet();
        send_byte(tx_q[0], w);
        intf.datain = tx_q[1];
        held = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (intf.busy !== 1'b1) held = 1'b0;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL bp_hold: busy dropped with 2 free words, required 1"); end
        pop_one(0, "bp");
        n_checks++;
        if (intf.busy !== 1'b1) begin n_fail++; $display("FAIL bp_one_pop: busy=%b with 3 free words, required 1", intf.busy); end
        pop_one(0, "bp");
        send_byte(tx_q[1], w);
        n_checks++;
        if (w != 1) begin n_fail++; $display("FAIL bp_release: busy cycles after 2nd pop %0d, required 1", w); end
        send_byte(tx_q[2], w);
        send_byte(tx_q[3], w);
        intf.packet_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL bp_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        drain(0, "bp");
    endtask

    task automatic test_timeout();
        int hw;
        int n;
        make_packet(2, 0, 1'b1);
        send_packet(hw);
        pop_one(2, "tmo");
        n = 0;
        while (1) begin
            @(negedge clk);
            if (intf.vldout[2] !== 1'b1) break;
            n++;
            if (n > 100) break;
        end
        @(posedge clk);
        #1;
        exp_q[2].delete();
        n_checks++;
        if (n != TIMEOUT) begin n_fail++; $display("FAIL tmo_cycles: unread-valid cycles %0d, required %0d", n, TIMEOUT); end
        n_checks++;
        if (tmo_cnt[2] != 1) begin n_fail++; $display("FAIL tmo_pulse: timeout[2] pulses %0d, required 1", tmo_cnt[2]); end
        n_checks++;
        if (intf.vldout !== 3'b000 || intf.data_out !== 24'h0) begin
            n_fail++;
            $display("FAIL tmo_flush: vldout=%b data_out=%h, required 000 0", intf.vldout, intf.data_out);
        end
    endtask

    task automatic test_back_to_back_wrap();
        bit done;
        int nread;
        done  = 1'b0;
        nread = 0;
        fork
            begin
                int hw;
                for (int k = 0; k < 4; k++) begin
                    make_packet(0, 6, 1'b1);
                    send_packet(hw);
                end
                done = 1'b1;
            end
            begin
                logic [7:0] got;
                logic [7:0] exp;
                int cyc;
                cyc = 0;
                intf.read_enb[0] = 1'b1;
                while (1) begin
                    @(negedge clk);
                    if (intf.vldout[0] === 1'b1) begin
                        got = intf.data_out[DATA_W-1:0];
                        exp = (exp_q[0].size() > 0) ? exp_q[0].pop_front() : 8'hXX;
                        nread++;
                        n_checks++;
                        if (got !== exp) begin
                            n_fail++;
                            $display("FAIL wrap_data word %0d: got %h, required %h", nread, got, exp);
                        end
                    end
                    if (done && exp_q[0].size() == 0) break;
                    cyc++;
                    if (cyc > 2000) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL wrap_bound: %0d words read, required 32", nread);
                        break;
                    end
                end
                @(posedge clk);
                #1;
                intf.read_enb[0] = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        n_checks++;
        if (nread != 32 || intf.vldout[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_total: words %0d vld=%b, required 32 0", nread, intf.vldout[0]);
        end
    endtask

    task automatic test_truncation();
        int w;
        int hw;
        make_packet(1, 3, 1'b1);
        exp_q[1].push_back(tx_q[0]);
        exp_q[1].push_back(tx_q[1]);
        exp_err++;
        send_byte(tx_q[0], w);
        send_byte(tx_q[1], w);
        intf.packet_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL trunc_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        n_checks++;
        if (intf.busy !== 1'b0 || intf.vldout !== 3'b010) begin
            n_fail++;
            $display("FAIL trunc_state: busy=%b vldout=%b, required 0 010", intf.busy, intf.vldout);
        end
        make_packet(1, 1, 1'b1);
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL trunc_next_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        drain(1, "trunc");
    endtask

    task automatic test_reset_mid_load();
        int w;
        int hw;
        make_packet(2, 3, 1'b1);
        send_byte(tx_q[0], w);
        send_byte(tx_q[1], w);
        intf.datain = tx_q[2];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        intf.packet_valid = 1'b0;
        n_checks++;
        if (intf.busy !== 1'b0 || intf.vldout !== 3'b000 || intf.data_out !== 24'h0 ||
            intf.err !== 1'b0 || intf.drop !== 1'b0 || intf.timeout !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_load: busy=%b vld=%b dout=%h err=%b drop=%b tmo=%b, required all 0",
                     intf.busy, intf.vldout, intf.data_out, intf.err, intf.drop, intf.timeout);
        end
        make_packet(2, 2, 1'b1);
        send_packet(hw);
        @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt != exp_err) begin n_fail++; $display("FAIL rst_next_err: err pulses %0d, required %0d", err_cnt, exp_err); end
        drain(2, "rst_next");
    endtask

    task automatic test_random();
        int dest;
        int len;
        int hw;
        bit good;
        for (int k = 0; k < 24; k++) begin
            dest = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 15));
            good = ($urandom_range(0, 3) != 0);
            make_packet(dest, len, good);
            send_packet(hw);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            n_checks++;
            if (err_cnt != exp_err) begin n_fail++; $display("FAIL rand_err pkt %0d: err pulses %0d, required %0d", k, err_cnt, exp_err); end
            n_checks++;
            if (drop_cnt != exp_drop) begin n_fail++; $display("FAIL rand_drop pkt %0d: drop pulses %0d, required %0d", k, drop_cnt, exp_drop); end
            if (dest < N_CH) drain(dest, "rand");
        end
        n_checks++;
        if (tmo_cnt[0] != 0 || tmo_cnt[1] != 0 || tmo_cnt[2] != 1) begin
            n_fail++;
            $display("FAIL tmo_total: pulses %0d %0d %0d, required 0 0 1", tmo_cnt[0], tmo_cnt[1], tmo_cnt[2]);
        end
    endtask

    initial begin
        intf.packet_valid = 1'b0;
        intf.datain       = '0;
        intf.read_enb     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_illegal_dest();
        test_back_pressure();
        test_timeout();
        test_back_to_back_wrap();
        test_truncation();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
